an_encoder_n13_frame: RTL and testbench

- Streaming AN-code encoder for the n13 6x6 array path.
- Accepts 3-bit messages one per handshake and encodes each as codeword = 13*message (6-bit).
- Assembles 36 codewords into a row-major 6x6 frame in a ping-pong buffer.
- Presents each completed frame as a flat parallel bus that maps directly onto the n13 array decoder's 36 codeword inputs (slot k feeds decoder input k).

---
 rtl/an_encoder_n13_frame.sv | 133 +++++++++++++
 tb/tb_an_encoder_n13_frame.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/an_encoder_n13_frame.sv
// AN-code (A=13) streaming encoder for the n13 6x6 array path.
// Messages are encoded one per handshake and collected row-major into a
// ping-pong pair of frame banks. A completed bank is presented as one flat
// bus whose slot k feeds decoder input k. Out-of-range messages are written
// as 0 and flag the bank until that bank is drained.
module an_encoder_n13_frame #(
    parameter int A     = 13,
    parameter int MSG_W = 3,
    parameter int CW_W  = 6,
    parameter int ROWS  = 6,
    parameter int COLS  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MSG_W-1:0]            in_msg,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*COLS*CW_W-1:0]   frame_data,
    output logic                        frame_err
);

    localparam int NSLOT   = ROWS * COLS;
    localparam int IDX_W   = $clog2(NSLOT);
    // Largest message whose codeword still fits in CW_W bits.
    localparam int MSG_MAX = ((2 ** CW_W) - 1) / A;

    // Frame storage and bookkeeping.
    logic [1:0][NSLOT-1:0][CW_W-1:0] r_bank;
    logic [1:0]                      r_full;
    logic [1:0]                      r_err;
    logic                            r_wr_bank;
    logic                            r_rd_bank;
    logic [IDX_W-1:0]                r_wr_idx;

    // Next-state values.
    logic [1:0][NSLOT-1:0][CW_W-1:0] w_bank_next;
    logic [1:0]                      w_full_next;
    logic [1:0]                      w_err_next;
    logic [IDX_W-1:0]                w_wr_idx_next;

    // Encoder and handshake terms.
    logic [CW_W-1:0] w_m;
    logic [CW_W-1:0] w_prod;
    logic [CW_W-1:0] w_cw;
    logic            w_range_err;
    logic            w_accept;
    logic            w_flush_go;
    logic            w_last;
    logic            w_close;
    logic            w_drain;

    // 13*m as shift-and-add; out-of-range messages become an all-zero slot.
    assign w_m         = CW_W'(in_msg);
    assign w_prod      = (w_m << 3) + (w_m << 2) + w_m;
    assign w_range_err = (in_msg > MSG_W'(MSG_MAX));
    assign w_cw        = w_range_err ? '0 : w_prod;

    // The write bank can take data until it is waiting to be drained.
    assign in_ready    = ~r_full[r_wr_bank];
    assign w_accept    = in_valid & in_ready;
    // A flush only closes a bank that holds (or is about to hold) data.
    assign w_flush_go  = flush & in_ready & ((r_wr_idx != '0) | w_accept);
    assign w_last      = w_accept & (r_wr_idx == IDX_W'(NSLOT - 1));
    assign w_close     = w_last | w_flush_go;

    assign out_valid   = r_full[r_rd_bank];
    assign frame_data  = r_bank[r_rd_bank];
    assign frame_err   = r_err[r_rd_bank];
    assign w_drain     = out_valid & out_ready;

    // Per-slot update: the accepted codeword lands at wr_idx; on a flush
    // every slot past the last written one is cleared so stale data from an
    // earlier frame in this bank never leaks out.
    genvar gb, gi;
    generate
        for (gb = 0; gb < 2; gb++) begin : g_bank
            for (gi = 0; gi < NSLOT; gi++) begin : g_slot
                assign w_bank_next[gb][gi] =
                    (w_accept && (r_wr_bank == 1'(gb)) && (r_wr_idx == IDX_W'(gi))) ? w_cw :
                    (w_flush_go && (r_wr_bank == 1'(gb)) && (IDX_W'(gi) >= r_wr_idx)) ? '0 :
                    r_bank[gb][gi];
            end
        end
    endgenerate

    // Full/err flags and write index: a fill and a drain always target
    // different banks, so both updates can be applied in the same cycle.
    always_comb begin
        w_full_next   = r_full;
        w_err_next    = r_err;
        w_wr_idx_next = r_wr_idx;
        if (w_accept && w_range_err) begin
            w_err_next[r_wr_bank] = 1'b1;
        end
        if (w_close) begin
            w_full_next[r_wr_bank] = 1'b1;
            w_wr_idx_next          = '0;
        end else if (w_accept) begin
            w_wr_idx_next = r_wr_idx + 1'b1;
        end
        if (w_drain) begin
            w_full_next[r_rd_bank] = 1'b0;
            w_err_next[r_rd_bank]  = 1'b0;
        end
    end

    // State registers; reset discards every partial and complete frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank    <= '0;
            r_full    <= '0;
            r_err     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            r_bank   <= w_bank_next;
            r_full   <= w_full_next;
            r_err    <= w_err_next;
            r_wr_idx <= w_wr_idx_next;
            if (w_close) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_drain) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_an_encoder_n13_frame.sv
// Testbench for an_encoder_n13_frame: directed scenarios plus a random
// stream, all checked against a frame-level model (message list -> frame).
module tb_an_encoder_n13_frame;

    localparam int NSLOT = 36;
    localparam int CW_W  = 6;
    localparam int FW    = NSLOT * CW_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_msg = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] frame_data;
    logic          frame_err;

    int errors = 0;
    int checks = 0;

    an_encoder_n13_frame dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_data (frame_data),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Completed frames waiting to leave, in fill order, plus the frame being
    // assembled as a plain list of codewords.
    logic [FW-1:0]   q_data[$];
    logic            q_err[$];
    logic [CW_W-1:0] cur_cw[NSLOT];
    int              cur_n = 0;
    logic            cur_err = 1'b0;
    logic [FW-1:0]   m_frame;
    bit              m_ready, m_acc, m_fl;

    // Model step evaluated mid-cycle for the upcoming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q_data.delete();
            q_err.delete();
            cur_n   = 0;
            cur_err = 1'b0;
        end else begin
            m_ready = (q_data.size() < 2);
            checks++;
            if (in_ready !== m_ready) begin
                errors++;
                $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, m_ready);
            end
            checks++;
            if (out_valid !== (q_data.size() > 0)) begin
                errors++;
                $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, q_data.size() > 0);
            end
            if (out_ready && q_data.size() > 0) begin
                checks++;
                if (frame_data !== q_data[0] || frame_err !== q_err[0]) begin
                    errors++;
                    $display("FAIL frame t=%0t got=%h/%b want=%h/%b", $time, frame_data, frame_err, q_data[0], q_err[0]);
                end else begin
                    $display("frame out t=%0t err=%b data=%h", $time, frame_err, frame_data);
                end
                void'(q_data.pop_front());
                void'(q_err.pop_front());
            end
            m_acc = in_valid && m_ready;
            m_fl  = flush && m_ready && (cur_n != 0 || m_acc);
            if (m_acc) begin
                cur_cw[cur_n] = (in_msg <= 4) ? CW_W'(13 * int'(in_msg)) : '0;
                if (in_msg > 4) cur_err = 1'b1;
                cur_n++;
            end
            if (m_fl || cur_n == NSLOT) begin
                m_frame = '0;
                for (int k = 0; k < NSLOT; k++)
                    if (k < cur_n) m_frame[k*CW_W +: CW_W] = cur_cw[k];
                q_data.push_back(m_frame);
                q_err.push_back(cur_err);
                cur_n   = 0;
                cur_err = 1'b0;
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_data !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got rdy=%b ov=%b fd=%h fe=%b want 1/0/0/0", in_ready, out_valid, frame_data, frame_err);
        end
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_msg   = 3'($urandom_range(0, 4));
            next_cycle();
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_data !== '0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b ov=%b fd=%h fe=%b want 1/0/0/0", in_ready, out_valid, frame_data, frame_err);
        end
        $display("reset mid-stream applied t=%0t", $time);
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        idle(40);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int k = 0; k < NSLOT; k++) begin
            in_valid = 1'b1;
            in_msg   = 3'(k % 5);
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid got ov=%b fe=%b want 1/0", out_valid, frame_err);
        end
        for (int k = 0; k < NSLOT; k++) begin
            checks++;
            if (frame_data[k*CW_W +: CW_W] !== CW_W'(13 * (k % 5))) begin
                errors++;
                $display("FAIL basic_slot%0d got=%0d want=%0d", k, frame_data[k*CW_W +: CW_W], 13 * (k % 5));
            end
        end
        next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle got ov=%b want 0", out_valid);
        end
        $display("basic frame done t=%0t", $time);
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int guard = 0;
        logic [FW-1:0] held;
        out_ready = 1'b0;
        while (sent < 72 && guard < 200) begin
            in_valid = 1'b1;
            in_msg   = 3'($urandom_range(0, 4));
            #2;
            if (in_ready) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 72) begin
            errors++;
            $display("FAIL bp_fill_timeout got=%0d want=72 accepts", sent);
        end
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got=%b want=0", in_ready);
        end
        held = frame_data;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            checks++;
            if (frame_data !== held || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable got=%h ov=%b want=%h ov=1", frame_data, out_valid, held);
            end
        end
        out_ready = 1'b1;
        next_cycle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_drain got=%b want=1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_msg   = 3'($urandom_range(0, 4));
            next_cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        next_cycle();
        flush    = 1'b0;
        idle(4);
        $display("backpressure done t=%0t", $time);
    endtask

    task automatic test_range_err();
        out_ready = 1'b1;
        for (int k = 0; k < NSLOT; k++) begin
            in_valid = 1'b1;
            in_msg   = (k == 10) ? 3'd7 : 3'd1;
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b1 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL range_flag got ov=%b fe=%b want 1/1", out_valid, frame_err);
        end
        for (int k = 0; k < NSLOT; k++) begin
            checks++;
            if (frame_data[k*CW_W +: CW_W] !== ((k == 10) ? 6'd0 : 6'd13)) begin
                errors++;
                $display("FAIL range_slot%0d got=%0d want=%0d", k, frame_data[k*CW_W +: CW_W], (k == 10) ? 0 : 13);
            end
        end
        next_cycle();
        for (int k = 0; k < NSLOT; k++) begin
            in_valid = 1'b1;
            in_msg   = 3'($urandom_range(0, 4));
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL range_clear got ov=%b fe=%b want 1/0", out_valid, frame_err);
        end
        idle(2);
        $display("range error done t=%0t", $time);
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_msg   = 3'd4;
            next_cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        next_cycle();
        flush    = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_valid got=%b want=1", out_valid);
        end
        for (int k = 0; k < NSLOT; k++) begin
            checks++;
            if (frame_data[k*CW_W +: CW_W] !== ((k < 5) ? 6'd52 : 6'd0)) begin
                errors++;
                $display("FAIL flush_slot%0d got=%0d want=%0d", k, frame_data[k*CW_W +: CW_W], (k < 5) ? 52 : 0);
            end
        end
        next_cycle();
        in_valid = 1'b1;
        in_msg   = 3'd3;
        next_cycle();
        in_valid = 1'b0;
        flush    = 1'b1;
        next_cycle();
        flush    = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b1 || frame_data[CW_W-1:0] !== 6'd39 || frame_data[FW-1:CW_W] !== '0) begin
            errors++;
            $display("FAIL flush_next_slot0 got ov=%b fd=%h want ov=1 slot0=39 rest 0", out_valid, frame_data);
        end
        idle(2);
        $display("flush done t=%0t", $time);
    endtask

    task automatic test_flush_accept();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_msg   = 3'd2;
            next_cycle();
        end
        in_msg = 3'd3;
        flush  = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        for (int k = 0; k < NSLOT; k++) begin
            checks++;
            if (frame_data[k*CW_W +: CW_W] !== ((k < 3) ? 6'd26 : (k == 3) ? 6'd39 : 6'd0)) begin
                errors++;
                $display("FAIL flushacc_slot%0d got=%0d want=%0d", k, frame_data[k*CW_W +: CW_W], (k < 3) ? 26 : (k == 3) ? 39 : 0);
            end
        end
        idle(2);
        $display("flush with accept done t=%0t", $time);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_msg    = 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        idle(5);
        checks++;
        if (q_data.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got pending=%0d ov=%b want 0/0", q_data.size(), out_valid);
        end
        $display("random stream done t=%0t", $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_range_err();
        test_flush();
        test_flush_accept();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
